// File: rtl/cache_pkg.sv
// Shared constants, state encoding and geometry helpers for the L1 data cache.
package cache_pkg;

  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned OFFSET_W  = 5;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned WSEL_W    = OFFSET_W - 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE        = 2'd0;
  localparam state_t WRITEBACK   = 2'd1;
  localparam state_t ALLOCATE    = 2'd2;
  localparam state_t REFILL_DONE = 2'd3;

  function automatic int unsigned index_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines);
    return addr_w - $clog2(lines) - OFFSET_W;
  endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle of the data cache.
interface dcache_controller_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_BITS = cache_pkg::LINE_BITS
);
  logic                 cpu_req_i;
  logic                 cpu_we_i;
  logic [ADDR_W-1:0]    cpu_addr_i;
  logic [31:0]          cpu_data_i;
  logic [31:0]          cpu_data_o;
  logic                 cpu_stall_o;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  // The cache itself.
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

  // Pipeline plus memory, seen from outside the cache.
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_sram.sv
// Valid/dirty/tag/data arrays: one combinational read port, one registered write port.
module dcache_sram import cache_pkg::*; #(
  parameter int unsigned LINES     = 16,
  parameter int unsigned LINE_BITS = cache_pkg::LINE_BITS,
  parameter int unsigned TAG_W     = 23
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [index_w(LINES)-1:0]   rd_idx,
  output logic                        rd_valid,
  output logic                        rd_dirty,
  output logic [TAG_W-1:0]            rd_tag,
  output logic [LINE_BITS-1:0]        rd_data,
  input  logic [index_w(LINES)-1:0]   wr_idx,
  input  logic                        wr_line,
  input  logic [TAG_W-1:0]            wr_tag,
  input  logic [LINE_BITS-1:0]        wr_line_data,
  input  logic                        wr_word,
  input  logic [WSEL_W-1:0]           wr_sel,
  input  logic [WORD_W-1:0]           wr_word_data
);
  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  // Read port
  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_dirty = dirty_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_data  = data_q[rd_idx];
  end

  // Line state: a refill makes a line valid and clean, a word store makes it dirty
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_line) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= 1'b0;
    end else if (wr_word) begin
      dirty_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage, not reset
  always_ff @(posedge clk_i) begin
    if (wr_line) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line_data;
    end else if (wr_word) begin
      data_q[wr_idx][WORD_W*int'(wr_sel) +: WORD_W] <= wr_word_data;
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate L1 data cache: FSM, request latch, hit/stall.
module dcache_controller import cache_pkg::*; #(
  parameter int unsigned LINES     = 16,
  parameter int unsigned LINE_BITS = cache_pkg::LINE_BITS,
  parameter int unsigned ADDR_W    = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  dcache_controller_if.slave  bus
);
  localparam int unsigned IDX_W = index_w(LINES);
  localparam int unsigned TAG_W = tag_w(ADDR_W, LINES);

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic [IDX_W-1:0]   req_idx_q, req_idx_d;

  logic [IDX_W-1:0]     cpu_idx, line_idx;
  logic [TAG_W-1:0]     cpu_tag;
  logic [WSEL_W-1:0]    cpu_wsel;
  logic [1:0]           addr_lsb_unused;
  logic                 rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 wr_line, wr_word;
  logic                 mem_req, mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [LINE_BITS-1:0] mem_data;
  logic [31:0]          cpu_data;
  logic                 cpu_stall;

  assign cpu_idx         = bus.cpu_addr_i[OFFSET_W +: IDX_W];
  assign cpu_tag         = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign cpu_wsel        = bus.cpu_addr_i[OFFSET_W-1:2];
  assign addr_lsb_unused = bus.cpu_addr_i[1:0];

  // Outside IDLE the arrays are addressed by the latched miss, not the live bus.
  assign line_idx = (state_q == IDLE) ? cpu_idx : req_idx_q;
  assign hit      = bus.cpu_req_i & rd_valid & (rd_tag == cpu_tag);

  dcache_sram #(
    .LINES     (LINES),
    .LINE_BITS (LINE_BITS),
    .TAG_W     (TAG_W)
  ) u_sram (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rd_idx       (line_idx),
    .rd_valid     (rd_valid),
    .rd_dirty     (rd_dirty),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .wr_idx       (line_idx),
    .wr_line      (wr_line),
    .wr_tag       (req_tag_q),
    .wr_line_data (bus.mem_data_i),
    .wr_word      (wr_word),
    .wr_sel       (cpu_wsel),
    .wr_word_data (bus.cpu_data_i)
  );

  // State register and latched miss address
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      req_tag_q <= '0;
      req_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      req_tag_q <= req_tag_d;
      req_idx_q <= req_idx_d;
    end
  end

  // Next-state logic; the request is captured on the miss cycle
  always_comb begin
    state_d   = state_q;
    req_tag_d = req_tag_q;
    req_idx_d = req_idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req_i && !hit) begin
          req_tag_d = cpu_tag;
          req_idx_d = cpu_idx;
          state_d   = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK:   if (bus.mem_ack_i) state_d = ALLOCATE;
      ALLOCATE:    if (bus.mem_ack_i) state_d = REFILL_DONE;
      REFILL_DONE: state_d = IDLE;
    endcase
  end

  // Outputs: memory bus decoded from the registered state, CPU side from the hit
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    wr_line  = 1'b0;
    unique case (state_q)
      IDLE: ;
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {rd_tag, req_idx_q, {OFFSET_W{1'b0}}};
        mem_data = rd_data;
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
        wr_line  = bus.mem_ack_i;
      end
      REFILL_DONE: ;
    endcase
    wr_word   = (state_q == IDLE) & hit & bus.cpu_we_i;
    cpu_stall = bus.cpu_req_i & ~((state_q == IDLE) & hit);
    cpu_data  = ((state_q == IDLE) && hit) ? rd_data[WORD_W*int'(cpu_wsel) +: WORD_W] : '0;
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_data_o  = mem_data;
  assign bus.cpu_data_o  = cpu_data;
  assign bus.cpu_stall_o = cpu_stall;
endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: vector table, scoreboarded memory model,
// hand-written reset and idle sequences.
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_controller_if #(.ADDR_W(32), .LINE_BITS(256)) bus ();

  dcache_controller #(
    .LINES     (16),
    .LINE_BITS (256),
    .ADDR_W    (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_stall;
    bit          exp_wb;
    logic [31:0] wb_addr;
    bit          exp_alloc;
    logic [31:0] alloc_addr;
  } vec_t;

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] mem     [256];
  logic [255:0] ref_mem [256];
  txn_t         sb [$];
  vec_t         vecs [$];
  bit           mem_auto   = 1'b1;
  logic         manual_ack = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int line, input int w);
    return 32'hA000_0000 | (line << 8) | w;
  endfunction

  function automatic vec_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp, input int stall, input bit wb,
                              input logic [31:0] wba, input bit al, input logic [31:0] ala);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp; v.exp_stall = stall;
    v.exp_wb = wb; v.wb_addr = wba; v.exp_alloc = al; v.alloc_addr = ala;
    return v;
  endfunction

  // Memory model: ack in the 10th cycle of each transaction; pops the scoreboard at start
  initial begin
    int          cnt;
    logic [31:0] start_addr;
    logic [7:0]  li;
    txn_t        e;
    cnt = 0;
    start_addr = '0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (!mem_auto) begin
        cnt = 0;
        bus.mem_ack_i = manual_ack;
      end else begin
        if (bus.mem_ack_i) begin
          bus.mem_ack_i = 1'b0;
          cnt = 0;
        end
        if (bus.mem_req_o && rst_n) begin
          cnt++;
          if (cnt == 1) begin
            start_addr = bus.mem_addr_o;
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL mem_unexpected: got we=%0b addr=%0h, expected no transaction",
                       bus.mem_we_o, bus.mem_addr_o);
            end else begin
              e = sb.pop_front();
              check("mem_we", bus.mem_we_o, e.we);
              check("mem_addr", bus.mem_addr_o, e.addr);
              if (e.we) check("mem_wb_data", bus.mem_data_o, e.data);
            end
          end
          if (cnt == 10) begin
            check("mem_addr_stable", bus.mem_addr_o, start_addr);
            li = bus.mem_addr_o[12:5];
            if (bus.mem_we_o) mem[li] = bus.mem_data_o;
            else bus.mem_data_i = mem[li];
            bus.mem_ack_i = 1'b1;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // One CPU access: queue expected memory traffic, drive, count stall cycles, check load data
  task automatic access(input vec_t v, input string name);
    int n;
    txn_t t;
    if (v.exp_wb) begin
      t.we = 1'b1; t.addr = v.wb_addr; t.data = ref_mem[v.wb_addr[12:5]];
      sb.push_back(t);
    end
    if (v.exp_alloc) begin
      t.we = 1'b0; t.addr = v.alloc_addr; t.data = '0;
      sb.push_back(t);
    end
    if (v.we) ref_mem[v.addr[12:5]][32*int'(v.addr[4:2]) +: 32] = v.wdata;
    @(negedge clk);
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = v.we;
    bus.cpu_addr_i = v.addr;
    bus.cpu_data_i = v.wdata;
    #1;
    n = 0;
    while (bus.cpu_stall_o && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({name, "_stall"}, n, v.exp_stall);
    if (!v.we) check({name, "_data"}, bus.cpu_data_o, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < 256; l++)
      for (int w = 0; w < 8; w++) mem[l][32*w +: 32] = pat(l, w);
    mem[0][31:0] = 32'd5;
    for (int l = 0; l < 256; l++) ref_mem[l] = mem[l];

    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_data_i = '0;

    //        we  addr          wdata         exp           stall wb  wb_addr       al  alloc_addr
    vecs.push_back(mk(0, 32'h000, 0,            32'd5,        12, 0, 0,            1, 32'h000));
    vecs.push_back(mk(1, 32'h004, 32'hDEADBEEF, 0,            0,  0, 0,            0, 0));
    vecs.push_back(mk(0, 32'h004, 0,            32'hDEADBEEF, 0,  0, 0,            0, 0));
    vecs.push_back(mk(0, 32'h200, 0,            pat(16, 0),   22, 1, 32'h000,      1, 32'h200));
    vecs.push_back(mk(0, 32'h000, 0,            32'd5,        12, 0, 0,            1, 32'h000));
    vecs.push_back(mk(0, 32'h004, 0,            32'hDEADBEEF, 0,  0, 0,            0, 0));
    vecs.push_back(mk(0, 32'h1E4, 0,            pat(15, 1),   12, 0, 0,            1, 32'h1E0));
    vecs.push_back(mk(1, 32'h3C0, 32'h12345678, 0,            12, 0, 0,            1, 32'h3C0));
    vecs.push_back(mk(0, 32'h3C0, 0,            32'h12345678, 0,  0, 0,            0, 0));
    vecs.push_back(mk(0, 32'h3C4, 0,            pat(30, 1),   0,  0, 0,            0, 0));
    vecs.push_back(mk(0, 32'h1E4, 0,            pat(15, 1),   0,  0, 0,            0, 0));
    vecs.push_back(mk(0, 32'h7C0, 0,            pat(62, 0),   22, 1, 32'h3C0,      1, 32'h7C0));
    vecs.push_back(mk(0, 32'hFFFFFFE4, 0,       pat(255, 1),  12, 0, 0,            1, 32'hFFFFFFE0));
    vecs.push_back(mk(1, 32'hFFFFFFFC, 32'hCAFEF00D, 0,       0,  0, 0,            0, 0));
    vecs.push_back(mk(0, 32'hFFFFFFFC, 0,       32'hCAFEF00D, 0,  0, 0,            0, 0));
    vecs.push_back(mk(0, 32'h1E0, 0,            pat(15, 0),   22, 1, 32'hFFFFFFE0, 1, 32'h1E0));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_stall", bus.cpu_stall_o, 1'b0);
    check("rst_mem_req", bus.mem_req_o, 1'b0);
    check("rst_mem_we", bus.mem_we_o, 1'b0);
    check("rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("rst_mem_data", bus.mem_data_o, 256'h0);
    check("rst_cpu_data", bus.cpu_data_o, 32'h0);

    foreach (vecs[i]) access(vecs[i], $sformatf("vec%0d", i));

    // Idle bus with random stray acks: nothing may move
    mem_auto = 1'b0;
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("idle_stall", bus.cpu_stall_o, 1'b0);
      check("idle_mem_req", bus.mem_req_o, 1'b0);
      check("idle_mem_data", bus.mem_data_o, 256'h0);
      manual_ack = 1'($urandom_range(0, 1));
    end
    manual_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_auto = 1'b1;
    access(mk(0, 32'h1E0, 0, pat(15, 0), 0, 0, 0, 0, 0), "idle_after_hit");
    // Dirty line 15 before reset; reset must drop it without a write-back
    access(mk(1, 32'h1E0, 32'h0BADF00D, 0, 0, 0, 0, 0, 0), "pre_rst_store");

    // Reset in the 5th ALLOCATE cycle of a miss to 0x400
    begin
      txn_t t;
      t.we = 1'b0; t.addr = 32'h400; t.data = '0;
      sb.push_back(t);
    end
    @(negedge clk);
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h400;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    bus.cpu_req_i = 1'b0;
    mem_auto = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_mem_req", bus.mem_req_o, 1'b0);
    check("midrst_mem_we", bus.mem_we_o, 1'b0);
    check("midrst_mem_addr", bus.mem_addr_o, 32'h0);
    check("midrst_stall", bus.cpu_stall_o, 1'b0);
    manual_ack = 1'b1;
    @(negedge clk);
    #1;
    manual_ack = 1'b0;
    @(negedge clk);
    #1;
    check("late_ack_mem_req", bus.mem_req_o, 1'b0);
    check("late_ack_stall", bus.cpu_stall_o, 1'b0);
    mem_auto = 1'b1;
    @(negedge clk);
    access(mk(0, 32'h400, 0, pat(32, 0), 12, 0, 0, 1, 32'h400), "reload_after_rst");
    access(mk(0, 32'h1E0, 0, pat(15, 0), 12, 0, 0, 1, 32'h1E0), "dirty_dropped");

    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
